// File: rtl/amsd_xmit.sv
// amsd_xmit: AM transmit back end. Scales audio by a programmable gain, adds
// a soft-started carrier bias, saturates to a unipolar level D and drives the
// RF pins through a sigma-delta modulator. Wishbone slave for control/status.
// Define AMSD_ORDER2_EN to build the second-order modulator instead of the
// default first-order one.
module amsd_xmit #(
  parameter int IW         = 12,
  parameter int GW         = 16,
  parameter int CW         = 14,
  parameter int NOUT       = 2,
  parameter int RAMP_SHIFT = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ce,
  input  logic [IW-1:0]   i_sample,
  input  logic            i_rf_en,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [1:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  input  logic [3:0]      i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  output logic [NOUT-1:0] o_rf_data,
  output logic            o_clip
);
  localparam int W  = IW + GW - 2;
  localparam int PW = IW + GW;
  localparam int LW = W + 3;
  localparam logic [CW:0] RAMP_STEP = (CW+1)'(2**RAMP_SHIFT);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, RUN = 2'd2} state_t;

  state_t                state;
  logic [GW-1:0]         r_gain;
  logic [CW-1:0]         r_carrier;
  logic [CW-1:0]         eff_carrier;
  logic signed [PW-1:0]  p;
  logic signed [PW-1:0]  sample_x;
  logic signed [PW-1:0]  gain_x;
  logic                  ce_d;
  logic [W-1:0]          d;
  logic [15:0]           clip_count;
  logic [LW-1:0]         carrier_term;
  logic signed [LW-1:0]  level;
  logic [W-1:0]          level_sat;
  logic                  level_clip;
  logic                  clip_event;
  logic [CW:0]           ramp_sum;
  logic [CW-1:0]         ramp_next;
  logic                  bus_req;
  logic                  bus_wr;
  logic                  status_wr;
  logic                  unused_bits;

  assign o_wb_stall  = 1'b0;
  assign bus_req     = i_wb_cyc & i_wb_stb;
  assign bus_wr      = bus_req & i_wb_we;
  assign status_wr   = bus_wr & (i_wb_addr == 2'd2);
  assign unused_bits = ^{i_wb_sel, i_wb_data};

  // Control registers written from the bus
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gain    <= {2'b01, {(GW-2){1'b0}}};
      r_carrier <= '0;
    end else if (bus_wr) begin
      if (i_wb_addr == 2'd0) r_gain    <= i_wb_data[GW-1:0];
      if (i_wb_addr == 2'd1) r_carrier <= i_wb_data[CW-1:0];
    end
  end

  assign sample_x = PW'($signed(i_sample));
  assign gain_x   = PW'($signed(r_gain));

  // Gain multiply on each sample strobe; ce_d marks the cycle p is fresh
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p    <= '0;
      ce_d <= 1'b0;
    end else begin
      ce_d <= i_ce;
      if (i_ce) p <= sample_x * gain_x;
    end
  end

  assign carrier_term = LW'(eff_carrier) << (W - CW);
  assign level        = LW'(p) + $signed(carrier_term);
  assign clip_event   = ce_d & level_clip;

  // Saturate the biased level into [0, FS-1]
  always_comb begin
    level_sat  = level[W-1:0];
    level_clip = 1'b0;
    if (level[LW-1]) begin
      level_sat  = '0;
      level_clip = 1'b1;
    end else if (level[LW-2:W] != '0) begin
      level_sat  = '1;
      level_clip = 1'b1;
    end
  end

  // Register the level once per sample along with the clip pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      d      <= '0;
      o_clip <= 1'b0;
    end else begin
      o_clip <= clip_event;
      if (ce_d) d <= level_sat;
    end
  end

  // Saturating clip counter; a clear coinciding with a clip leaves one count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      clip_count <= '0;
    end else if (status_wr) begin
      clip_count <= clip_event ? 16'd1 : 16'd0;
    end else if (clip_event && clip_count != 16'hFFFF) begin
      clip_count <= clip_count + 16'd1;
    end
  end

  // Next ramp value, clamped to the (possibly lowered) target
  always_comb begin
    ramp_sum  = {1'b0, eff_carrier} + RAMP_STEP;
    ramp_next = (ramp_sum > {1'b0, r_carrier}) ? r_carrier : ramp_sum[CW-1:0];
  end

  // Carrier soft-start state machine
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_rf_en) begin
      state       <= IDLE;
      eff_carrier <= '0;
    end else begin
      case (state)
        IDLE: begin
          state       <= RAMP;
          eff_carrier <= '0;
        end
        RAMP: begin
          if (eff_carrier == r_carrier) state <= RUN;
          else if (i_ce)                eff_carrier <= ramp_next;
        end
        RUN:     eff_carrier <= r_carrier;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AMSD_ORDER2_EN
  localparam logic [LW-1:0] FS_VAL = LW'(1) << W;
  logic signed [LW-1:0] e1;
  logic signed [LW-1:0] e2;
  logic signed [LW-1:0] e1_next;
  logic signed [LW-1:0] fb;
  logic                 y;

  assign y       = ~e2[LW-1];
  assign fb      = y ? $signed(FS_VAL) : '0;
  assign e1_next = e1 + $signed(LW'(d)) - fb;

  // Second-order modulator; e2 integrates the freshly updated e1
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_rf_en) begin
      e1        <= '0;
      e2        <= '0;
      o_rf_data <= '0;
    end else begin
      e1        <= e1_next;
      e2        <= e2 + e1_next - fb;
      o_rf_data <= {NOUT{y}};
    end
  end
`else
  logic [W:0] acc;

  // First-order modulator: the carry out of the accumulator is the bitstream
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_rf_en) begin
      acc       <= '0;
      o_rf_data <= '0;
    end else begin
      acc       <= {1'b0, acc[W-1:0]} + {1'b0, d};
      o_rf_data <= {NOUT{acc[W]}};
    end
  end
`endif

  // Wishbone ack and registered read data
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= bus_req;
      if (bus_req) begin
        case (i_wb_addr)
          2'd0:    o_wb_data <= 32'(r_gain);
          2'd1:    o_wb_data <= 32'(r_carrier);
          2'd2:    o_wb_data <= {state, 14'd0, clip_count};
          default: o_wb_data <= 32'(d);
        endcase
      end
    end
  end
endmodule
